// File: rtl/alu_acc.sv
// Accumulator ALU with independently enabled accumulator and carry registers.
// Operand mux and flag_s are combinational; the accumulator and the carry, zero and overflow flags are registered.
module alu_acc #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       data_src,
    input  logic [WIDTH-1:0] immediate,
    input  logic [WIDTH-1:0] reg_out,
    input  logic [WIDTH-1:0] mem_out,
    input  logic [2:0]       op,
    input  logic             ce_a,
    input  logic             ce_cy,
    output logic [WIDTH-1:0] alu_in,
    output logic [WIDTH-1:0] acc_v,
    output logic             flag_cy,
    output logic             flag_z,
    output logic             flag_s,
    output logic             flag_o
);

    localparam int unsigned MSB = WIDTH - 1;

    localparam logic [2:0] OP_LOAD = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_ADC  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_RLC  = 3'b111;

    logic [WIDTH-1:0] result_c;
    logic             carry_c;
    logic             ovf_c;
    logic [WIDTH:0]   ext_acc;
    logic [WIDTH:0]   ext_in;
    logic [WIDTH:0]   ext_cy;

    // Operand select: bit 0 clear always means memory, so 2'b10 aliases to mem_out.
    always_comb begin
        alu_in = mem_out;
        if (data_src[0]) begin
            alu_in = data_src[1] ? reg_out : immediate;
        end
    end

    assign ext_acc = {1'b0, acc_v};
    assign ext_in  = {1'b0, alu_in};
    assign ext_cy  = {{WIDTH{1'b0}}, flag_cy};

    // Result, carry-out and signed overflow from the pre-edge accumulator and carry.
    always_comb begin
        result_c = acc_v;
        carry_c  = flag_cy;
        ovf_c    = 1'b0;
        case (op)
            OP_LOAD: result_c = alu_in;
            OP_ADD: begin
                {carry_c, result_c} = ext_acc + ext_in;
                ovf_c = (acc_v[MSB] == alu_in[MSB]) && (result_c[MSB] != acc_v[MSB]);
            end
            OP_ADC: begin
                {carry_c, result_c} = ext_acc + ext_in + ext_cy;
                ovf_c = (acc_v[MSB] == alu_in[MSB]) && (result_c[MSB] != acc_v[MSB]);
            end
            OP_SUB: begin
                // Top bit of the extended difference is the unsigned borrow.
                {carry_c, result_c} = ext_acc - ext_in;
                ovf_c = (acc_v[MSB] != alu_in[MSB]) && (result_c[MSB] != acc_v[MSB]);
            end
            OP_AND: begin
                result_c = acc_v & alu_in;
                carry_c  = 1'b0;
            end
            OP_OR: begin
                result_c = acc_v | alu_in;
                carry_c  = 1'b0;
            end
            OP_XOR: begin
                result_c = acc_v ^ alu_in;
                carry_c  = 1'b0;
            end
            OP_RLC: begin
                result_c = {acc_v[MSB-1:0], flag_cy};
                carry_c  = acc_v[MSB];
            end
        endcase
    end

    // Accumulator group and carry have separate enables; reset overrides both.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_v   <= '0;
            flag_z  <= 1'b0;
            flag_o  <= 1'b0;
            flag_cy <= 1'b0;
        end else begin
            if (ce_a) begin
                acc_v  <= result_c;
                flag_z <= (result_c == '0);
                flag_o <= ovf_c;
            end
            if (ce_cy) begin
                flag_cy <= carry_c;
            end
        end
    end

    assign flag_s = acc_v[MSB];

endmodule

// File: doc/alu_acc.md
ALU_ACC -- requirements
Module: alu_acc

Interface
REQ-001 SHALL have parameter: WIDTH, 8, data path width in bits (WIDTH >= 2).
REQ-002 SHALL have ports, one clock, reset synchronous and active-high:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- data_src  in  2  operand select (data_src_t): 2'b?0 mem, 2'b01 imm, 2'b11 reg
- immediate  in  WIDTH  immediate operand
- reg_out  in  WIDTH  register operand
- mem_out  in  WIDTH  memory operand
- op  in  3  ALU operation
- ce_a  in  1  clock-enable for accumulator, flag_z and flag_o
- ce_cy  in  1  clock-enable for carry
- alu_in  out  WIDTH  selected operand (combinational)
- acc_v  out  WIDTH  accumulator (registered)
- flag_cy  out  1  carry/borrow (registered)
- flag_z  out  1  zero (registered with accumulator)
- flag_s  out  1  sign (combinational from acc_v)
- flag_o  out  1  signed overflow (registered)

Function
REQ-003 alu_in SHALL be mem_out when data_src[0]=0, immediate when data_src=2'b01, and reg_out when data_src=2'b11, with zero cycles of latency.
REQ-004 The result R (WIDTH bits) and carry-out C SHALL be computed combinationally from acc_v, alu_in and flag_cy:
- 000 LOAD: R=alu_in; C=flag_cy (held)
- 001 ADD: {C,R}=acc_v+alu_in
- 010 ADC: {C,R}=acc_v+alu_in+flag_cy
- 011 SUB: R=acc_v-alu_in mod 2^WIDTH; C=1 iff acc_v<alu_in unsigned (borrow)
- 100 AND, 101 OR, 110 XOR: bitwise with alu_in; C=0
- 111 RLC: R={acc_v[WIDTH-2:0],flag_cy}; C=acc_v[WIDTH-1]; alu_in ignored
REQ-005 Signed overflow V SHALL be 1 for ADD/ADC when the operands have equal MSBs and R's MSB differs, 1 for SUB when the operand MSBs differ and R's MSB differs from acc_v's MSB, and 0 for all other ops.
REQ-006 On a clock edge with rst=0 and ce_a=1: acc_v<=R, flag_z<=(R==0), flag_o<=V.
REQ-007 On a clock edge with rst=0 and ce_a=0: acc_v, flag_z and flag_o SHALL hold.
REQ-008 On a clock edge with rst=0 and ce_cy=1: flag_cy<=C, computed from pre-edge acc_v and flag_cy.
REQ-009 ce_cy and ce_a SHALL be independent; with ce_cy=1 and ce_a=0 the carry updates while the accumulator holds.
REQ-010 On a clock edge with rst=0 and ce_cy=0: flag_cy SHALL hold.
REQ-011 ADC and RLC SHALL use the pre-edge flag_cy even when ce_cy=1 in the same cycle.
REQ-012 flag_s SHALL equal acc_v[WIDTH-1] combinationally at all times.
REQ-013 All arithmetic SHALL wrap modulo 2^WIDTH; no saturation.
REQ-014 The result SHALL be visible on acc_v and flags exactly one clock after the enabling edge; back-to-back enabled ops SHALL chain on consecutive cycles.
REQ-015 Unlisted data_src encodings SHALL NOT exist; 2'b10 SHALL select mem_out.

Reset
REQ-016 On a clock edge with rst=1: acc_v, flag_cy, flag_z and flag_o SHALL be 0, and hence flag_s SHALL be 0.
REQ-017 rst SHALL override ce_a and ce_cy in the same cycle.
REQ-018 rst SHALL have no asynchronous effect; outputs SHALL change only at a clock edge.
REQ-019 alu_in SHALL remain combinational during reset.

Verification
REQ-020 Reset: rst=1 for 1 edge with ce_a=ce_cy=1, op=LOAD, immediate=0xAA -> acc_v=0x00, all flags 0.
REQ-021 Overflow: LOAD imm 0x7F, then ADD imm 0x01, ce_a=ce_cy=1 -> acc_v=0x80, flag_o=1, flag_cy=0, flag_s=1, flag_z=0.
REQ-022 Carry and zero: LOAD mem 0xFF (data_src=2'b10), then ADD mem 0x01 -> acc_v=0x00, flag_cy=1, flag_z=1, flag_o=0.
REQ-023 ADC/SUB chain: flag_cy=1 and acc_v=0x10, ADC reg 0x20 -> 0x31 with cy=0, then SUB imm 0x32 -> acc_v=0xFF, flag_cy=1, flag_s=1, flag_o=0.
REQ-024 Enables: acc_v=0x81, flag_cy=0, op=RLC, ce_a=0, ce_cy=1 -> acc_v=0x81 held, flag_cy=1; next edge with ce_a=1, ce_cy=0 -> acc_v=0x03, flag_cy=1 held.
REQ-025 Reset mid-stream: the ADD sequence of REQ-021 with rst=1 on the ADD edge -> acc_v=0x00, all flags 0; next edge ADD imm 0x01 -> acc_v=0x01.
